// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern transmitter and the serial
// sequence detectors it feeds: FSM state encoding, output reset values and
// default pattern geometry.
package serial_pkg;

    // Default maximum pattern length and width of the length field.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Output values while in reset.
    localparam logic W_RST       = 1'b0;
    localparam logic W_VALID_RST = 1'b0;
    localparam logic BUSY_RST    = 1'b0;
    localparam logic DONE_RST    = 1'b0;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Request/status bundle of the serial pattern transmitter.
//   start, pattern, len, repeat_cnt : request side (driven by the master)
//   w, w_valid, busy, done          : serial output and status (driven by the slave)
interface serial_pattern_tx_if #(
    parameter int WIDTH = serial_pkg::DEF_WIDTH,
    parameter int LEN_W = serial_pkg::DEF_LEN_W
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [3:0]       repeat_cnt;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, repeat_cnt,
        input  w, w_valid, busy, done
    );

    modport slave (
        input  start, pattern, len, repeat_cnt,
        output w, w_valid, busy, done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register. Loads d on load, otherwise shifts
// left by one on shift; msb is the bit currently at the top.
//   clk, resetn : clock, async active-low reset
//   load, shift : load has priority over shift
//   d           : parallel load value
//   msb         : current most significant bit
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);
    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load)       sr_d = d;
        else if (shift) sr_d = sr_q << 1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sr_q <= '0;
        else         sr_q <= sr_d;
    end

    assign msb = sr_q[WIDTH-1];
endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter. On start (in IDLE) latches pattern, the
// clamped length and repeat count, then sends pattern[len-1:0] MSB-first on w,
// one bit per clock, repeat_cnt+1 times with a one-cycle gap between passes.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : start/pattern/len/repeat_cnt in, w/w_valid/busy/done out
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    serial_pattern_tx_if.slave    bus
);
    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] pat_q, pat_d;         // latched pattern, first bit at MSB
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d; // bits left after the one on w
    logic [3:0]       rep_q, rep_d;
    logic             w_q, w_d;
    logic             w_valid_q, w_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;
    logic             sr_load, sr_shift, sr_msb;
    logic [WIDTH-1:0] sr_din;

    assign eff_len = (bus.len > WIDTH_L) ? WIDTH_L : bus.len;
    assign aligned = bus.pattern << (WIDTH_L - eff_len);

    // The first bit of each pass goes straight to w_q at the load edge, so the
    // shift register is loaded one position ahead and its msb is always the
    // next bit to send.
    piso_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk    (clk),
        .resetn (resetn),
        .load   (sr_load),
        .shift  (sr_shift),
        .d      (sr_din),
        .msb    (sr_msb)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && eff_len != '0) state_d = SHIFT;
            SHIFT:   if (bit_cnt_q == '0) state_d = (rep_q != '0) ? GAP : IDLE;
            GAP:     state_d = SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        len_d     = len_q;
        pat_d     = pat_q;
        bit_cnt_d = bit_cnt_q;
        rep_d     = rep_q;
        w_d       = 1'b0;
        w_valid_d = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != IDLE);
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_din    = pat_q << 1;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (eff_len != '0) begin
                        len_d     = eff_len;
                        pat_d     = aligned;
                        rep_d     = bus.repeat_cnt;
                        bit_cnt_d = eff_len - 1'b1;
                        sr_load   = 1'b1;
                        sr_din    = aligned << 1;
                        w_d       = aligned[WIDTH-1];
                        w_valid_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    w_d       = sr_msb;
                    w_valid_d = 1'b1;
                    sr_shift  = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d = rep_q - 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            GAP: begin
                bit_cnt_d = len_q - 1'b1;
                sr_load   = 1'b1;
                w_d       = pat_q[WIDTH-1];
                w_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_q     <= '0;
            pat_q     <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            w_q       <= W_RST;
            w_valid_q <= W_VALID_RST;
            busy_q    <= BUSY_RST;
            done_q    <= DONE_RST;
        end else begin
            len_q     <= len_d;
            pat_q     <= pat_d;
            bit_cnt_q <= bit_cnt_d;
            rep_q     <= rep_d;
            w_q       <= w_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.w       = w_q;
    assign bus.w_valid = w_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
